// File: rtl/ssd_pkg.sv
// ----------------------------------------------------------------------------
// ssd_pkg
//   Shared constants and helpers for the seven-segment scan driver.
//   SEG_OFF    : all cathodes (segments + dp) dark, active-low.
//   ANODE_OFF  : single anode "off" level, replicate to the digit count.
//   idx_width  : width of a digit index, never less than 1 bit.
//   seg7       : hex nibble -> {a,b,c,d,e,f,g}, active-low.
// ----------------------------------------------------------------------------
package ssd_pkg;

    localparam logic [7:0] SEG_OFF   = 8'hFF;
    localparam logic       ANODE_OFF = 1'b1;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/ssd_hex_decoder.sv
// ----------------------------------------------------------------------------
// ssd_hex_decoder
//   Combinational hex nibble to seven-segment decoder (active-low).
//   i_nib : 4-bit hex value
//   o_seg : {a,b,c,d,e,f,g}, 0 = segment lit
// ----------------------------------------------------------------------------
module ssd_hex_decoder
    import ssd_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    assign o_seg = seg7(i_nib);

endmodule

// File: rtl/ssd_scan_driver.sv
// ----------------------------------------------------------------------------
// ssd_scan_driver
//   Time-multiplexed seven-segment scan driver. Each digit owns a slot of
//   2**SCAN_DIV_BITS clocks; the first BLANK_CYCLES clocks of every slot are
//   dark to stop ghosting while the anode switches. New data is captured into
//   a pending shadow on load and only copied to the displayed (active) copy on
//   the frame wrap, so a frame never mixes old and new digits.
//
//   Optional build macro SSD_LZB_EN: leading-zero blanking on the active data.
//
//   Ports:
//     ClkPort     system clock
//     Reset_n     asynchronous active-low reset
//     digits_in   hex nibbles, digit i = [4i+3:4i]
//     dp_in       decimal point request per digit
//     digit_en    per-digit display enable
//     load        capture digits_in/dp_in/digit_en into pending
//     An          anodes, active-low
//     Cathodes    {Ca..Cg,Dp}, active-low
//     scan_idx    digit currently owning the slot
//     frame_tick  one-cycle pulse when the scan wraps to digit 0
// ----------------------------------------------------------------------------
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS    = 8,
    parameter int SCAN_DIV_BITS = 18,
    parameter int BLANK_CYCLES  = 1024
) (
    input  logic                                 ClkPort,
    input  logic                                 Reset_n,
    input  logic [4*NUM_DIGITS-1:0]              digits_in,
    input  logic [NUM_DIGITS-1:0]                dp_in,
    input  logic [NUM_DIGITS-1:0]                digit_en,
    input  logic                                 load,
    output logic [NUM_DIGITS-1:0]                An,
    output logic [7:0]                           Cathodes,
    output logic [idx_width(NUM_DIGITS)-1:0]     scan_idx,
    output logic                                 frame_tick
);

    localparam int                       IDX_W    = idx_width(NUM_DIGITS);
    localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [SCAN_DIV_BITS-1:0] BLANK_V  = SCAN_DIV_BITS'(BLANK_CYCLES);

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
        $error("ssd_scan_driver: NUM_DIGITS must be 1..8");
    end
    if (BLANK_CYCLES < 0 || BLANK_CYCLES >= (1 << SCAN_DIV_BITS)) begin : g_bad_blank
        $error("ssd_scan_driver: BLANK_CYCLES must be below 2**SCAN_DIV_BITS");
    end

    logic [SCAN_DIV_BITS-1:0]  r_presc;
    logic [IDX_W-1:0]          r_idx;
    logic                      r_tick;
    logic [4*NUM_DIGITS-1:0]   r_pend_dig, r_act_dig;
    logic [NUM_DIGITS-1:0]     r_pend_dp,  r_act_dp;
    logic [NUM_DIGITS-1:0]     r_pend_en,  r_act_en;
    logic [NUM_DIGITS-1:0]     r_an;
    logic [7:0]                r_cat;

    logic                      w_presc_tc;
    logic                      w_frame_wrap;
    logic [NUM_DIGITS-1:0]     w_lzb_mask;
    logic [3:0]                w_nib;
    logic                      w_dp;
    logic                      w_en;
    logic                      w_lzb;
    logic                      w_dark;
    logic [6:0]                w_seg;
    logic [NUM_DIGITS-1:0]     w_an_on;

    assign w_presc_tc   = &r_presc;
    assign w_frame_wrap = w_presc_tc && (r_idx == LAST_IDX);

    // Prescaler and slot counter. Disabled digits keep their slot so the
    // refresh rate does not depend on what is displayed.
    always_ff @(posedge ClkPort or negedge Reset_n) begin
        if (!Reset_n) begin
            r_presc <= '0;
            r_idx   <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_presc <= r_presc + 1'b1;
            r_tick  <= w_frame_wrap;
            if (w_presc_tc)
                r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
        end
    end

    // Pending shadow follows every load; active only changes on the wrap.
    // A load on the wrap cycle itself goes straight to active so it is not
    // delayed by a whole frame.
    always_ff @(posedge ClkPort or negedge Reset_n) begin
        if (!Reset_n) begin
            r_pend_dig <= '0;
            r_pend_dp  <= '0;
            r_pend_en  <= '0;
            r_act_dig  <= '0;
            r_act_dp   <= '0;
            r_act_en   <= '0;
        end else begin
            if (load) begin
                r_pend_dig <= digits_in;
                r_pend_dp  <= dp_in;
                r_pend_en  <= digit_en;
            end
            if (w_frame_wrap) begin
                r_act_dig <= load ? digits_in : r_pend_dig;
                r_act_dp  <= load ? dp_in     : r_pend_dp;
                r_act_en  <= load ? digit_en  : r_pend_en;
            end
        end
    end

`ifdef SSD_LZB_EN
    // Walk down from the top digit; the run of blanked digits ends at the
    // first non-zero nibble or lit dp. Digit 0 is never part of the run.
    logic w_zero_run;
    always_comb begin
        w_lzb_mask = '0;
        w_zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_zero_run    = w_zero_run && (r_act_dig[4*i +: 4] == 4'h0) && !r_act_dp[i];
            w_lzb_mask[i] = w_zero_run;
        end
    end
`else
    assign w_lzb_mask = '0;
`endif

    // Select the active digit for the current slot.
    always_comb begin
        w_nib = 4'h0;
        w_dp  = 1'b0;
        w_en  = 1'b0;
        w_lzb = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nib = r_act_dig[4*i +: 4];
                w_dp  = r_act_dp[i];
                w_en  = r_act_en[i];
                w_lzb = w_lzb_mask[i];
            end
        end
    end

    ssd_hex_decoder u_dec (
        .i_nib (w_nib),
        .o_seg (w_seg)
    );

    assign w_an_on = ~(NUM_DIGITS'(1) << r_idx);
    assign w_dark  = (r_presc < BLANK_V) || !w_en || w_lzb;

    // Registered outputs so the pads see clean, glitch-free levels.
    always_ff @(posedge ClkPort or negedge Reset_n) begin
        if (!Reset_n) begin
            r_an  <= {NUM_DIGITS{ANODE_OFF}};
            r_cat <= SEG_OFF;
        end else if (w_dark) begin
            r_an  <= {NUM_DIGITS{ANODE_OFF}};
            r_cat <= SEG_OFF;
        end else begin
            r_an  <= w_an_on;
            r_cat <= {w_seg, ~w_dp};
        end
    end

    assign An         = r_an;
    assign Cathodes   = r_cat;
    assign scan_idx   = r_idx;
    assign frame_tick = r_tick;

endmodule
